password_dispatcher: RTL and testbench
======================================

# password_dispatcher

Hands out stored passwords to NUM_CORES cracking cores, one password per grant, in list order. It sits between the password storage block (index table of password start offsets, password count, ready flag) and the hash/compare cores. It arbitrates core requests round-robin, reads the start offset and end offset of each password from the index table, and grants the core the start address and length. It stops on the first reported match or when the list is exhausted.

## Interface
- NUM_CORES, 4, number of requesting cores (2..16)
- CORE_W, 2, width of core index (clog2 of NUM_CORES)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- store_ready  in  1  index table populated; sampled only in IDLE
- password_count  in  32  number of valid index-table entries
- mem_end  in  32  byte address of the EOF terminator
- idx_rd_addr  out  32  index-table read address; reset 0
- idx_rd_data  in  32  index-table entry; valid 1 cycle after idx_rd_addr
- req  in  NUM_CORES  per-core request; held high until granted
- found  in  NUM_CORES  per-core match pulse
- grant_valid  out  1  one-cycle grant strobe; reset 0
- grant  out  NUM_CORES  one-hot granted core, valid with grant_valid; reset 0
- pw_start  out  32  password start byte address; reset 0
- pw_len  out  32  password length in bytes; reset 0
- match_found  out  1  sticky; reset 0
- found_core  out  CORE_W  lowest-numbered core with found set; reset 0
- exhausted  out  1  sticky, all passwords dispatched; reset 0
- busy  out  1  high outside IDLE/DONE; reset 0

## Operation
- States: IDLE, ARB, RD1, RD2, GRANT, DONE.
- IDLE: on store_ready=1, clear next_idx to 0, go to ARB.
- ARB:
  - If next_idx >= password_count, set exhausted and go to DONE.
  - Otherwise, if req is nonzero, select a core round-robin. The search starts at rr_ptr, which is last granted + 1 and resets to 0. Latch the core, drive idx_rd_addr=next_idx, go to RD1.
  - If req is zero, stay in ARB.
- RD1: capture start=idx_rd_data. If next_idx+1 < password_count, drive idx_rd_addr=next_idx+1. Go to RD2.
- RD2: end = idx_rd_data-1 (EOL byte address) if next_idx is not the last entry; otherwise end = mem_end. Go to GRANT.
- GRANT:
  - Drive grant_valid=1, grant=onehot(core), pw_start=start, pw_len = end-start (32-bit unsigned).
  - If end < start, pw_len=0.
  - Increment next_idx, set rr_ptr=core+1 (wraps to 0), go to ARB.
- found:
  - Sampled every cycle in ARB..GRANT.
  - Any bit set: next state DONE, match_found=1, found_core=lowest set index.
  - found takes priority over exhaustion and over a pending grant. A GRANT cycle already in progress completes.
- DONE: terminal; leave only by reset. grant_valid stays 0.
- A core dropping req before its grant is not supported; the dispatcher has already committed the selection.

## Timing
- grant_valid rises 3 cycles after the ARB cycle that selected a core. Peak throughput is one grant per 4 cycles.
- idx_rd_addr is registered. idx_rd_data is expected exactly 1 cycle later.
- pw_start, pw_len, and grant hold their values until the next grant.
- found seen at edge T: match_found=1 after T; grant_valid is 0 from T+1 onward.
- password_count=0: IDLE→ARB→DONE with exhausted=1; no grant is issued.
- Reset asserted mid-operation: all outputs return to their reset values immediately; rr_ptr and next_idx are cleared.

## Configuration
- DISPATCH_STATS_EN defined: adds two output ports, both reset 0.
  - dispatched_count (32): increments on every grant_valid.
  - stall_cycles (32): increments every ARB cycle with req=0 and next_idx < password_count.
  - Both saturate at 0xFFFFFFFF.
- DISPATCH_STATS_EN undefined: these ports and their counters do not exist. All other behaviour is identical.

## Test plan
- Index table {0,6,13}, mem_end=20, password_count=3, req=0001 constant → three grants to core 0 with (start,len) = (0,5), (6,6), (13,7), then exhausted=1 and busy=0.
- NUM_CORES=4, req=1111 constant, password_count=8 → grant order 0,1,2,3,0,1,2,3, grant_valid every 4th cycle.
- found=0100 asserted during RD1 of the 2nd password → no further grant_valid, match_found=1, found_core=2. found=0110 → found_core=1.
- password_count=0, store_ready=1 → exhausted=1 within 2 cycles, no grant_valid.
- rst low during RD2 → all outputs 0 asynchronously. After release and store_ready, the first grant is to core 0 with next_idx=0.
- With DISPATCH_STATS_EN: 3 grants and 5 idle ARB cycles → dispatched_count=3, stall_cycles=5.

Source files
------------

// File: rtl/password_dispatcher.sv
// rtl/password_dispatcher.sv - round-robin password grant dispatcher; optional counters under DISPATCH_STATS_EN
module password_dispatcher #(
    parameter int NUM_CORES = 4,
    parameter int CORE_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 store_ready,
    input  logic [31:0]          password_count,
    input  logic [31:0]          mem_end,
    output logic [31:0]          idx_rd_addr,
    input  logic [31:0]          idx_rd_data,
    input  logic [NUM_CORES-1:0] req,
    input  logic [NUM_CORES-1:0] found,
    output logic                 grant_valid,
    output logic [NUM_CORES-1:0] grant,
    output logic [31:0]          pw_start,
    output logic [31:0]          pw_len,
    output logic                 match_found,
    output logic [CORE_W-1:0]    found_core,
    output logic                 exhausted,
    output logic                 busy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]          dispatched_count,
    output logic [31:0]          stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD1,
        S_RD2,
        S_GRANT,
        S_DONE
    } state_t;

    state_t                 state;
    logic [31:0]            next_idx;
    logic [31:0]            start_addr;
    logic [CORE_W-1:0]      rr_ptr;
    logic [CORE_W-1:0]      core;
    logic [CORE_W-1:0]      sel_core;
    logic                   sel_hit;
    logic [CORE_W-1:0]      found_low;
    logic [2*NUM_CORES-1:0] req_dbl;
    logic [NUM_CORES-1:0]   req_rot;
    logic [32:0]            idx_plus1;
    logic                   is_last;
    logic [31:0]            end_addr;
    logic [31:0]            len_calc;
    logic                   active;

    // Round-robin pick: rotate req so rr_ptr sits at bit 0, then take the lowest set bit
    always_comb begin
        int off;
        int sum;
        req_dbl = {req, req} >> rr_ptr;
        req_rot = req_dbl[NUM_CORES-1:0];
        off     = 0;
        sel_hit = 1'b0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                off     = i;
                sel_hit = 1'b1;
            end
        end
        sum = int'(rr_ptr) + off;
        if (sum >= NUM_CORES) begin
            sum = sum - NUM_CORES;
        end
        sel_core = CORE_W'(sum);
    end

    // Lowest-numbered core reporting a match this cycle
    always_comb begin
        found_low = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found[i]) begin
                found_low = CORE_W'(i);
            end
        end
    end

    // End address of the current password and its clamped length; the last entry ends at mem_end
    always_comb begin
        idx_plus1 = {1'b0, next_idx} + 33'd1;
        is_last   = (idx_plus1 >= {1'b0, password_count});
        end_addr  = is_last ? mem_end : (idx_rd_data - 32'd1);
        len_calc  = (end_addr < start_addr) ? 32'd0 : (end_addr - start_addr);
    end

    assign active = (state == S_ARB) || (state == S_RD1) ||
                    (state == S_RD2) || (state == S_GRANT);

    // Dispatch FSM with registered outputs; a match report overrides everything except finishing a GRANT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            next_idx    <= '0;
            start_addr  <= '0;
            rr_ptr      <= '0;
            core        <= '0;
            idx_rd_addr <= '0;
            grant_valid <= 1'b0;
            grant       <= '0;
            pw_start    <= '0;
            pw_len      <= '0;
            match_found <= 1'b0;
            found_core  <= '0;
            exhausted   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            grant_valid <= 1'b0;
            if (active && (|found)) begin
                match_found <= 1'b1;
                found_core  <= found_low;
                busy        <= 1'b0;
                state       <= S_DONE;
                if (state == S_GRANT) begin
                    next_idx <= next_idx + 32'd1;
                    rr_ptr   <= (core == CORE_W'(NUM_CORES - 1)) ? '0 : core + CORE_W'(1);
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (store_ready) begin
                            next_idx <= '0;
                            busy     <= 1'b1;
                            state    <= S_ARB;
                        end
                    end
                    S_ARB: begin
                        if (next_idx >= password_count) begin
                            exhausted <= 1'b1;
                            busy      <= 1'b0;
                            state     <= S_DONE;
                        end else if (sel_hit) begin
                            core        <= sel_core;
                            idx_rd_addr <= next_idx;
                            state       <= S_RD1;
                        end
                    end
                    S_RD1: begin
                        start_addr <= idx_rd_data;
                        if (!is_last) begin
                            idx_rd_addr <= idx_plus1[31:0];
                        end
                        state <= S_RD2;
                    end
                    S_RD2: begin
                        grant_valid <= 1'b1;
                        grant       <= {{(NUM_CORES-1){1'b0}}, 1'b1} << core;
                        pw_start    <= start_addr;
                        pw_len      <= len_calc;
                        state       <= S_GRANT;
                    end
                    S_GRANT: begin
                        next_idx <= next_idx + 32'd1;
                        rr_ptr   <= (core == CORE_W'(NUM_CORES - 1)) ? '0 : core + CORE_W'(1);
                        state    <= S_ARB;
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DISPATCH_STATS_EN
    // Grant and stall counters, both saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dispatched_count <= '0;
            stall_cycles     <= '0;
        end else begin
            if (grant_valid && (dispatched_count != 32'hFFFF_FFFF)) begin
                dispatched_count <= dispatched_count + 32'd1;
            end
            if ((state == S_ARB) && (req == '0) && (next_idx < password_count) &&
                (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_password_dispatcher.sv
// tb/tb_password_dispatcher.sv - self-checking bench for password_dispatcher
module tb_password_dispatcher;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        store_ready;
    logic [31:0] password_count;
    logic [31:0] mem_end;
    logic [31:0] idx_rd_addr;
    logic [31:0] idx_rd_data;
    logic [3:0]  req;
    logic [3:0]  found;
    logic        grant_valid;
    logic [3:0]  grant;
    logic [31:0] pw_start;
    logic [31:0] pw_len;
    logic        match_found;
    logic [1:0]  found_core;
    logic        exhausted;
    logic        busy;
`ifdef DISPATCH_STATS_EN
    logic [31:0] dispatched_count;
    logic [31:0] stall_cycles;
`endif

    logic [31:0] tbl [16];
    assign idx_rd_data = tbl[idx_rd_addr[3:0]];

    always #5 clk = ~clk;

    password_dispatcher #(.NUM_CORES(NC), .CORE_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .store_ready    (store_ready),
        .password_count (password_count),
        .mem_end        (mem_end),
        .idx_rd_addr    (idx_rd_addr),
        .idx_rd_data    (idx_rd_data),
        .req            (req),
        .found          (found),
        .grant_valid    (grant_valid),
        .grant          (grant),
        .pw_start       (pw_start),
        .pw_len         (pw_len),
        .match_found    (match_found),
        .found_core     (found_core),
        .exhausted      (exhausted),
        .busy           (busy)
`ifdef DISPATCH_STATS_EN
        ,
        .dispatched_count (dispatched_count),
        .stall_cycles     (stall_cycles)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int          obs_cyc   [$];
    logic [3:0]  obs_grant [$];
    logic [31:0] obs_start [$];
    logic [31:0] obs_len   [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && grant_valid) begin
            obs_cyc.push_back(cyc);
            obs_grant.push_back(grant);
            obs_start.push_back(pw_start);
            obs_len.push_back(pw_len);
        end
    end

    typedef struct {
        logic [3:0]  mask;
        int          cnt;
        logic [31:0] me;
        int          exp_n;
        logic [31:0] exp_cores;
        logic [31:0] exp_len0;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic init_tbl();
        logic [31:0] v [16];
        v = '{0, 6, 13, 21, 22, 22, 40, 50, 55, 61, 70, 80, 90, 100, 110, 120};
        for (int i = 0; i < 16; i++) tbl[i] = v[i];
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        store_ready = 1'b0;
        req         = '0;
        found       = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        obs_cyc.delete();
        obs_grant.delete();
        obs_start.delete();
        obs_len.delete();
    endtask

    task automatic start_run();
        store_ready = 1'b1;
        @(negedge clk);
        store_ready = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (exhausted || match_found) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (grant_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reference: first core at or after ptr (cyclically) whose request bit is set
    function automatic int rr_pick(input logic [3:0] m, input int ptr);
        for (int i = 0; i < NC; i++) begin
            int c;
            c = (ptr + i) % NC;
            if (((m >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    // Reference: length of password k from the index table
    function automatic logic [31:0] ref_len(input int k, input int cnt, input logic [31:0] me);
        logic [31:0] s;
        logic [31:0] e;
        s = tbl[k];
        e = (k == cnt - 1) ? me : tbl[k + 1] - 32'd1;
        return (e < s) ? 32'd0 : e - s;
    endfunction

    task automatic check_run(input string tag, input logic [3:0] mask, input int cnt, input logic [31:0] me);
        int ptr;
        int n;
        ptr = 0;
        chk({tag, "_ngrants"}, obs_grant.size(), cnt);
        n = (obs_grant.size() < cnt) ? obs_grant.size() : cnt;
        for (int k = 0; k < n; k++) begin
            int c;
            c   = rr_pick(mask, ptr);
            ptr = (c + 1) % NC;
            chk($sformatf("%s_grant%0d", tag, k), obs_grant[k], 32'd1 << c);
            chk($sformatf("%s_start%0d", tag, k), obs_start[k], tbl[k]);
            chk($sformatf("%s_len%0d", tag, k), obs_len[k], ref_len(k, cnt, me));
            if (k > 0) chk($sformatf("%s_gap%0d", tag, k), obs_cyc[k] - obs_cyc[k - 1], 4);
        end
        chk({tag, "_exhausted"}, exhausted, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_match"}, match_found, 0);
    endtask

    task automatic run_scn(input string tag, input logic [3:0] mask, input int cnt, input logic [31:0] me);
        bit ok;
        do_reset();
        password_count = cnt;
        mem_end        = me;
        req            = mask;
        start_run();
        wait_end(400, ok);
        chk({tag, "_finished"}, ok, 1);
        repeat (3) @(negedge clk);
        check_run(tag, mask, cnt, me);
    endtask

    task automatic found_seq(input logic [3:0] fv, input logic [1:0] exp_core);
        bit ok;
        int g;
        do_reset();
        init_tbl();
        password_count = 3;
        mem_end        = 20;
        req            = 4'b0001;
        start_run();
        wait_grant(ok);
        chk("found_first_grant", ok, 1);
        @(negedge clk);
        @(negedge clk);
        found = fv;
        @(negedge clk);
        found = '0;
        chk("found_match", match_found, 1);
        chk("found_core", found_core, exp_core);
        chk("found_busy", busy, 0);
        chk("found_not_exhausted", exhausted, 0);
        g = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant_valid) g++;
        end
        chk("found_no_more_grants", g, 0);
        chk("found_hold_start", pw_start, 0);
        chk("found_hold_len", pw_len, 5);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [5];
        bit   ok;
        int   g;

        rst            = 1'b0;
        store_ready    = 1'b0;
        req            = '0;
        found          = '0;
        password_count = '0;
        mem_end        = '0;
        init_tbl();

        @(negedge clk);
        chk("reset_grant_valid", grant_valid, 0);
        chk("reset_grant", grant, 0);
        chk("reset_pw_start", pw_start, 0);
        chk("reset_pw_len", pw_len, 0);
        chk("reset_idx_rd_addr", idx_rd_addr, 0);
        chk("reset_flags", {match_found, exhausted, busy, found_core}, 0);

        vecs[0] = '{4'b0001, 3, 32'd20, 3, 32'h0000_0000, 32'd5};
        vecs[1] = '{4'b1111, 8, 32'd60, 8, 32'h3210_3210, 32'd5};
        vecs[2] = '{4'b1010, 5, 32'd60, 5, 32'h0001_3131, 32'd5};
        vecs[3] = '{4'b0100, 2, 32'd60, 2, 32'h0000_0022, 32'd5};
        vecs[4] = '{4'b1111, 0, 32'd60, 0, 32'h0000_0000, 32'd0};

        for (int v = 0; v < 5; v++) begin
            logic [31:0] ec;
            init_tbl();
            run_scn($sformatf("vec%0d", v), vecs[v].mask, vecs[v].cnt, vecs[v].me);
            ec = vecs[v].exp_cores;
            chk($sformatf("vec%0d_count", v), obs_grant.size(), vecs[v].exp_n);
            for (int k = 0; k < vecs[v].exp_n && k < obs_grant.size(); k++) begin
                chk($sformatf("vec%0d_core%0d", v, k), obs_grant[k], 32'd1 << ec[k*4 +: 4]);
            end
            if (vecs[v].exp_n > 0 && obs_len.size() > 0) begin
                chk($sformatf("vec%0d_len0", v), obs_len[0], vecs[v].exp_len0);
            end
        end

        found_seq(4'b0100, 2'd2);
        found_seq(4'b0110, 2'd1);

        do_reset();
        init_tbl();
        password_count = 0;
        req            = 4'b1111;
        store_ready    = 1'b1;
        @(negedge clk);
        store_ready = 1'b0;
        @(negedge clk);
        chk("empty_exhausted_2cyc", exhausted, 1);
        chk("empty_busy", busy, 0);
        g = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (grant_valid) g++;
        end
        chk("empty_no_grant", g, 0);

        do_reset();
        init_tbl();
        password_count = 3;
        mem_end        = 20;
        req            = 4'b0010;
        start_run();
        wait_grant(ok);
        chk("rst_first_grant_seen", ok, 1);
        chk("rst_first_grant_core1", grant, 4'b0010);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_len", pw_len, 5);
        #1 rst = 1'b0;
        #1;
        chk("rst_async_grant_valid", grant_valid, 0);
        chk("rst_async_grant", grant, 0);
        chk("rst_async_pw_start", pw_start, 0);
        chk("rst_async_pw_len", pw_len, 0);
        chk("rst_async_idx_rd_addr", idx_rd_addr, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        req = 4'b1111;
        @(negedge clk);
        start_run();
        wait_grant(ok);
        chk("rst_regrant_seen", ok, 1);
        chk("rst_regrant_core0", grant, 4'b0001);
        chk("rst_regrant_start", pw_start, 0);
        chk("rst_regrant_len", pw_len, 5);

`ifdef DISPATCH_STATS_EN
        do_reset();
        init_tbl();
        password_count = 3;
        mem_end        = 20;
        req            = 4'b0000;
        store_ready    = 1'b1;
        @(negedge clk);
        store_ready = 1'b0;
        repeat (5) @(negedge clk);
        req = 4'b0001;
        wait_end(100, ok);
        chk("stats_finished", ok, 1);
        repeat (2) @(negedge clk);
        chk("stats_dispatched", dispatched_count, 3);
        chk("stats_stall", stall_cycles, 5);
`endif

        for (int r = 0; r < 25; r++) begin
            int          cnt;
            logic [3:0]  mask;
            logic [31:0] me;
            for (int i = 0; i < 16; i++) begin
                tbl[i] = (i == 0) ? 32'($urandom_range(0, 7)) : tbl[i - 1] + 32'($urandom_range(0, 9));
            end
            cnt  = $urandom_range(1, 12);
            mask = 4'($urandom_range(1, 15));
            me   = tbl[cnt - 1] + 32'($urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0 && tbl[cnt - 1] > 0) me = tbl[cnt - 1] - 32'd1;
            run_scn($sformatf("rnd%0d", r), mask, cnt, me);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
